// File: rtl/minirisc_pkg.sv
// Shared types and constants for the KGP-miniRISC datapath blocks.
package minirisc_pkg;

  localparam int WIDTH = 32;
  localparam int SLICE = 16;

  // Sequencer states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sub_slice_16bit.sv
// 16-bit subtract slice: sum = a + ~b + cin, built from four 4-bit
// carry-lookahead groups joined by a second-level lookahead unit.
module sub_slice_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // 4-bit lookahead: c[i] is the carry out of bit i, each written as a
  // flat sum of products so no carry ripples through another.
  function automatic logic [3:0] cla4(input logic [3:0] g,
                                      input logic [3:0] p,
                                      input logic       ci);
    logic [3:0] c;
    logic       term;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] cb;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [3:0]  gc;
  logic [3:0]  t;
  logic        cin_k;

  // Bit propagate/generate on the inverted subtrahend, group terms,
  // group carries, then per-bit carries inside each group.
  always_comb begin
    p     = a ^ ~b;
    g     = a & ~b;
    gg    = '0;
    gp    = '0;
    cb    = '0;
    t     = '0;
    cin_k = 1'b0;
    for (int k = 0; k < 4; k++) begin
      t     = cla4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      gg[k] = t[3];
      gp[k] = &p[4*k +: 4];
    end
    gc = cla4(gg, gp, cin);
    for (int k = 0; k < 4; k++) begin
      cin_k         = (k == 0) ? cin : gc[(k == 0) ? 0 : k - 1];
      t             = cla4(g[4*k +: 4], p[4*k +: 4], cin_k);
      cb[4*k +: 4]  = {t[2:0], cin_k};
    end
    sum  = p ^ cb;
    cout = gc[3];
  end

endmodule

// File: rtl/sub_serial_32bit.sv
// Two-cycle 32-bit subtractor: one shared 16-bit slice processes the low
// half, then the high half, behind a start/done handshake.
module sub_serial_32bit #(
  parameter int WIDTH = minirisc_pkg::WIDTH,
  parameter int SLICE = minirisc_pkg::SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  import minirisc_pkg::*;

  state_t                   state_q;
  state_t                   state_d;
  logic signed [WIDTH-1:0]  a_q;
  logic signed [WIDTH-1:0]  b_q;
  logic                     c16_q;
  logic        [SLICE-1:0]  lo_q;
  logic        [WIDTH-1:0]  diff_q;
  logic                     borrow_q;
  logic                     zero_q;
  logic                     neg_q;
  logic                     ovf_q;

  logic                     accept;
  logic        [SLICE-1:0]  sl_a;
  logic        [SLICE-1:0]  sl_b;
  logic                     sl_cin;
  logic        [SLICE-1:0]  sl_sum;
  logic                     sl_cout;
  logic        [WIDTH-1:0]  full_diff;

  // Shared slice operand mux: high half in HI, low half otherwise.
  always_comb begin
    sl_a   = a_q[SLICE-1:0];
    sl_b   = b_q[SLICE-1:0];
    sl_cin = 1'b1;
    if (state_q == HI) begin
      sl_a   = a_q[WIDTH-1:SLICE];
      sl_b   = b_q[WIDTH-1:SLICE];
      sl_cin = c16_q;
    end
  end

  sub_slice_16bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (sl_cin),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  assign full_diff = {sl_sum, lo_q};

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (start) begin accept = 1'b1; state_d = LO; end
      LO:   state_d = HI;
      HI:   state_d = DONE;
      DONE: begin
        if (start) begin accept = 1'b1; state_d = LO; end
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch, low-half staging and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c16_q    <= 1'b0;
      lo_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      // LO -> HI: stage the low half; visible diff stays untouched.
      if (state_q == LO) begin
        lo_q  <= sl_sum;
        c16_q <= sl_cout;
      end
      // HI -> DONE: publish the full result and flags together.
      if (state_q == HI) begin
        diff_q   <= full_diff;
        borrow_q <= ~sl_cout;
        zero_q   <= (full_diff == '0);
        neg_q    <= full_diff[WIDTH-1];
        ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (full_diff[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign busy   = (state_q == LO) || (state_q == HI);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_sub_serial_32bit.sv
// Bench for sub_serial_32bit: directed corner operands, random operands,
// handshake corner cases and mid-operation reset.
module tb_sub_serial_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        borrow;
  logic        zero;
  logic        neg;
  logic        ovf;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last_diff;

  sub_serial_32bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero),
    .neg    (neg),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: plain modular/integer arithmetic on the operands.
  task automatic check_result(input string tag, input logic [31:0] ea, input logic [31:0] eb);
    logic [31:0] ed;
    longint      sd;
    logic        eovf;
    ed   = ea - eb;
    sd   = longint'($signed(ea)) - longint'($signed(eb));
    eovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    chk({tag, "_diff"},   diff,            ed);
    chk({tag, "_borrow"}, 32'(borrow),     32'(ea < eb));
    chk({tag, "_zero"},   32'(zero),       32'(ed == 32'd0));
    chk({tag, "_neg"},    32'(neg),        32'(sd < 0 ? !eovf : eovf));
    chk({tag, "_ovf"},    32'(ovf),        32'(eovf));
    last_diff = ed;
  endtask

  // One complete operation from IDLE, starting on a falling edge.
  task automatic do_op(input string tag, input logic [31:0] oa, input logic [31:0] ob);
    start = 1'b1;
    a     = oa;
    b     = ob;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    @(negedge clk);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd1);
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
    chk({tag, "_hold_lo"}, diff,      last_diff);
    step();
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    chk({tag, "_done_hi"}, 32'(done), 32'd0);
    chk({tag, "_hold_hi"}, diff,      last_diff);
    step();
    chk({tag, "_done"},    32'(done), 32'd1);
    chk({tag, "_busy_dn"}, 32'(busy), 32'd0);
    check_result(tag, oa, ob);
    step();
    chk({tag, "_done_idle"}, 32'(done), 32'd0);
    chk({tag, "_hold_idle"}, diff,      last_diff);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    last_diff = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_diff",   diff,        32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_zero",   32'(zero),   32'd1);
    chk("rst_neg",    32'(neg),    32'd0);
    chk("rst_ovf",    32'(ovf),    32'd0);
    rst_n = 1'b1;
    step();

    do_op("five_minus_three", 32'd5,          32'd3);
    do_op("half_borrow",      32'h0001_0000,  32'h0000_0001);
    do_op("zero_minus_one",   32'h0000_0000,  32'h0000_0001);
    do_op("equal",            32'h1234_ABCD,  32'h1234_ABCD);
    do_op("ovf_neg_to_pos",   32'h8000_0000,  32'h0000_0001);
    do_op("ovf_pos_to_neg",   32'h7FFF_FFFF,  32'hFFFF_FFFF);
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = (i % 6 == 5) ? ra : $urandom;
      do_op("random", ra, rb);
    end

    // start pulsed in LO is ignored; start held through DONE issues back-to-back.
    start = 1'b1;
    a     = 32'h0000_1000;
    b     = 32'h0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0007;
    chk("b2b_hold_lo", diff, last_diff);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy_hi", 32'(busy), 32'd1);
    chk("b2b_done_hi", 32'(done), 32'd0);
    start = 1'b1;
    a     = 32'h0000_0003;
    b     = 32'h0000_0009;
    step();
    chk("b2b_first_done", 32'(done), 32'd1);
    check_result("b2b_first", 32'h0000_1000, 32'h0000_0001);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    @(negedge clk);
    chk("b2b_second_busy", 32'(busy), 32'd1);
    chk("b2b_second_nodone", 32'(done), 32'd0);
    step();
    chk("b2b_second_busy_hi", 32'(busy), 32'd1);
    chk("b2b_second_nodone_hi", 32'(done), 32'd0);
    step();
    chk("b2b_second_done", 32'(done), 32'd1);
    check_result("b2b_second", 32'h0000_0003, 32'h0000_0009);
    step();
    chk("b2b_idle", 32'(done), 32'd0);

    // Reset asserted during HI aborts the operation with no done.
    start = 1'b1;
    a     = 32'h0000_0010;
    b     = 32'h0000_0020;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    step();
    chk("abort_busy_hi", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    chk("abort_busy",   32'(busy), 32'd0);
    chk("abort_done",   32'(done), 32'd0);
    chk("abort_diff",   diff,      32'd0);
    chk("abort_zero",   32'(zero), 32'd1);
    chk("abort_borrow", 32'(borrow), 32'd0);
    rst_n     = 1'b1;
    last_diff = 32'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle",    32'(busy), 32'd0);
    end
    do_op("after_abort", 32'h0000_0100, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
